// File: rtl/bitmap_encoder_pkg.sv
// Shared types and helpers for the sequential bitmap encoder.
// Optional count feature is enabled by defining BITMAP_ENCODER_COUNT_EN.
package bitmap_encoder_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_e;

  // Index width for a bitmap of the given width (at least one bit).
  function automatic int idx_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/bitmap_encoder_seq_lsb_find.sv
// Combinational lowest-set-bit finder: index, bitmap with that bit cleared,
// zero flag and an "at most one bit set" flag.
module lsb_find #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 3
) (
  input  logic [WIDTH-1:0] data,
  output logic [IDX_W-1:0] idx,
  output logic [WIDTH-1:0] cleared,
  output logic             zero,
  output logic             le_one
);

  // Scan from the top so the last hit, the lowest set bit, wins.
  always_comb begin
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (data[i]) idx = IDX_W'(i);
    end
  end

  assign cleared = data & (data - WIDTH'(1));
  assign zero    = ~|data;
  assign le_one  = ~|cleared;

endmodule

// File: rtl/bitmap_encoder_seq.sv
// Sequential multi-hot encoder: one set-bit index per output beat, lowest
// first. Define BITMAP_ENCODER_COUNT_EN to add the out_cnt popcount port.
module bitmap_encoder_seq
  import bitmap_encoder_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int IDX_W = idx_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_none,
`ifdef BITMAP_ENCODER_COUNT_EN
  output logic [IDX_W:0]   out_cnt,
`endif
  output state_e           dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high; valid never depends on ready, but in_ready depends on
  // out_ready so a new bitmap can be taken on the last beat of the previous.

  state_e state_q, state_d;

  logic [WIDTH-1:0] pending_q;
  logic [IDX_W-1:0] idx_q;
  logic             last_q;
  logic             none_q;

  logic [IDX_W-1:0] in_idx, pend_idx;
  logic [WIDTH-1:0] in_cleared, pend_cleared;
  logic             in_zero, in_le_one, pend_zero, pend_le_one;

  logic accept;
  logic out_fire;

  lsb_find #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_in_lsb (
    .data    (in_data),
    .idx     (in_idx),
    .cleared (in_cleared),
    .zero    (in_zero),
    .le_one  (in_le_one)
  );

  lsb_find #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_pend_lsb (
    .data    (pending_q),
    .idx     (pend_idx),
    .cleared (pend_cleared),
    .zero    (pend_zero),
    .le_one  (pend_le_one)
  );

  assign out_valid = (state_q == ST_EMIT);
  assign out_fire  = out_valid && out_ready;
  assign in_ready  = (state_q == ST_IDLE) || (out_fire && last_q);
  assign accept    = in_valid && in_ready;

  assign out_idx   = idx_q;
  assign out_last  = last_q;
  assign out_none  = none_q;
  assign dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_EMIT;
      ST_EMIT: if (out_fire && last_q && !accept) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // A fresh accept takes priority; otherwise advance through pending bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      idx_q     <= '0;
      last_q    <= 1'b0;
      none_q    <= 1'b0;
    end else if (accept) begin
      pending_q <= in_cleared;
      idx_q     <= in_idx;
      last_q    <= in_le_one;
      none_q    <= in_zero;
    end else if (out_fire && !last_q) begin
      pending_q <= pend_cleared;
      idx_q     <= pend_idx;
      last_q    <= pend_le_one || pend_zero;
    end
  end

`ifdef BITMAP_ENCODER_COUNT_EN
  logic [IDX_W:0] in_pop;
  logic [IDX_W:0] cnt_q;

  always_comb begin
    in_pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      in_pop = in_pop + (IDX_W + 1)'(in_data[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         cnt_q <= '0;
    else if (accept) cnt_q <= in_pop;
  end

  assign out_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_bitmap_encoder_seq.sv
// Directed bench for bitmap_encoder_seq: table-driven bitmaps on an 8-bit
// instance plus hand sequences for stall, back-to-back and mid-burst reset.
module tb_bitmap_encoder_seq;
  import bitmap_encoder_pkg::*;

  logic clk;
  logic rst;

  logic       in_valid8, in_ready8, out_valid8, out_ready8, out_last8, out_none8;
  logic [7:0] in_data8;
  logic [2:0] out_idx8;
  state_e     dbg8;

  logic        in_valid16, in_ready16, out_valid16, out_ready16, out_last16, out_none16;
  logic [15:0] in_data16;
  logic [3:0]  out_idx16;
  state_e      dbg16;

`ifdef BITMAP_ENCODER_COUNT_EN
  logic [3:0] out_cnt8;
  logic [4:0] out_cnt16;
`endif

  int checks;
  int failures;

  logic [3:0] exp_q[$];

  typedef struct {
    logic [7:0]  data;
    int          n;
    logic [31:0] idxs;
    logic        none;
    logic [3:0]  cnt;
  } vec_t;

  vec_t vecs[8];

  bitmap_encoder_seq #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .in_data   (in_data8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .out_idx   (out_idx8),
    .out_last  (out_last8),
    .out_none  (out_none8),
`ifdef BITMAP_ENCODER_COUNT_EN
    .out_cnt   (out_cnt8),
`endif
    .dbg_state (dbg8)
  );

  bitmap_encoder_seq #(.WIDTH(16)) dut16 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid16),
    .in_ready  (in_ready16),
    .in_data   (in_data16),
    .out_valid (out_valid16),
    .out_ready (out_ready16),
    .out_idx   (out_idx16),
    .out_last  (out_last16),
    .out_none  (out_none16),
`ifdef BITMAP_ENCODER_COUNT_EN
    .out_cnt   (out_cnt16),
`endif
    .dbg_state (dbg16)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check8(input string tag, input logic v, input logic [2:0] idx,
                        input logic last, input logic none, input logic rdy);
    check({tag, ".out_valid"}, out_valid8, v);
    check({tag, ".out_idx"},   out_idx8,   idx);
    check({tag, ".out_last"},  out_last8,  last);
    check({tag, ".out_none"},  out_none8,  none);
    check({tag, ".in_ready"},  in_ready8,  rdy);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    in_valid8  = 1'b0;
    in_data8   = '0;
    out_ready8 = 1'b0;
    in_valid16 = 1'b0;
    in_data16  = '0;
    out_ready16 = 1'b0;

    vecs[0] = '{data: 8'h04, n: 1, idxs: 32'h0000_0002, none: 1'b0, cnt: 4'd1};
    vecs[1] = '{data: 8'hA6, n: 4, idxs: 32'h0000_7521, none: 1'b0, cnt: 4'd4};
    vecs[2] = '{data: 8'h00, n: 1, idxs: 32'h0000_0000, none: 1'b1, cnt: 4'd0};
    vecs[3] = '{data: 8'hFF, n: 8, idxs: 32'h7654_3210, none: 1'b0, cnt: 4'd8};
    vecs[4] = '{data: 8'h80, n: 1, idxs: 32'h0000_0007, none: 1'b0, cnt: 4'd1};
    vecs[5] = '{data: 8'h01, n: 1, idxs: 32'h0000_0000, none: 1'b0, cnt: 4'd1};
    vecs[6] = '{data: 8'h5A, n: 4, idxs: 32'h0000_6431, none: 1'b0, cnt: 4'd4};
    vecs[7] = '{data: 8'h03, n: 2, idxs: 32'h0000_0010, none: 1'b0, cnt: 4'd2};

    // Reset values
    cyc();
    cyc();
    rst = 1'b0;
    #1;
    check8("reset", 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    check("reset.dbg_state", dbg8, ST_IDLE);
    check("reset16.out_valid", out_valid16, 1'b0);
    check("reset16.in_ready", in_ready16, 1'b1);
`ifdef BITMAP_ENCODER_COUNT_EN
    check("reset.out_cnt", out_cnt8, 4'd0);
`endif

    // Table-driven bitmaps with out_ready held high
    for (int v = 0; v < 8; v++) begin
      cyc();
      in_valid8  = 1'b1;
      in_data8   = vecs[v].data;
      out_ready8 = 1'b1;
      #1;
      check("tbl.idle_in_ready", in_ready8, 1'b1);
      for (int k = 0; k < vecs[v].n; k++) exp_q.push_back(vecs[v].idxs[4*k +: 4]);
      cyc();
      in_valid8 = 1'b0;
      in_data8  = 8'($urandom_range(0, 255));
      for (int k = 0; k < vecs[v].n; k++) begin
        logic [3:0] e;
        if (k > 0) cyc();
        #1;
        e = exp_q.pop_front();
        check8($sformatf("tbl%0d.beat%0d", v, k), 1'b1, e[2:0],
               (k == vecs[v].n - 1), vecs[v].none, (k == vecs[v].n - 1));
`ifdef BITMAP_ENCODER_COUNT_EN
        check($sformatf("tbl%0d.out_cnt", v), out_cnt8, vecs[v].cnt);
`endif
      end
      cyc();
      #1;
      check($sformatf("tbl%0d.drained", v), out_valid8, 1'b0);
    end

    // Stall: 8'h18 with three stalled cycles on the first beat
    cyc();
    in_valid8  = 1'b1;
    in_data8   = 8'h18;
    out_ready8 = 1'b1;
    cyc();
    in_valid8  = 1'b0;
    out_ready8 = 1'b0;
    for (int s = 0; s < 3; s++) begin
      #1;
      check8($sformatf("stall%0d", s), 1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
      cyc();
    end
    out_ready8 = 1'b1;
    #1;
    check8("stall.release", 1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
    cyc();
    #1;
    check8("stall.second", 1'b1, 3'd4, 1'b1, 1'b0, 1'b1);
    cyc();
    #1;
    check("stall.no_dup", out_valid8, 1'b0);

    // Back-to-back 8'h81 then 8'h01, second accept on the last beat
    cyc();
    in_valid8 = 1'b1;
    in_data8  = 8'h81;
    cyc();
    in_data8  = 8'h01;
    #1;
    check8("b2b.beat0", 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
    cyc();
    #1;
    check8("b2b.beat1", 1'b1, 3'd7, 1'b1, 1'b0, 1'b1);
    cyc();
    in_valid8 = 1'b0;
    #1;
    check8("b2b.beat2", 1'b1, 3'd0, 1'b1, 1'b0, 1'b1);
    check("b2b.dbg_state", dbg8, ST_EMIT);
`ifdef BITMAP_ENCODER_COUNT_EN
    check("b2b.out_cnt", out_cnt8, 4'd1);
`endif
    cyc();
    #1;
    check("b2b.idle", out_valid8, 1'b0);

    // WIDTH=16 all-ones, reset after the fifth beat
    cyc();
    in_valid16  = 1'b1;
    in_data16   = 16'hFFFF;
    out_ready16 = 1'b1;
    cyc();
    in_valid16 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) cyc();
      #1;
      check($sformatf("w16.beat%0d.idx", k), out_idx16, 4'(k));
      check($sformatf("w16.beat%0d.last", k), out_last16, 1'b0);
`ifdef BITMAP_ENCODER_COUNT_EN
      check("w16.out_cnt", out_cnt16, 5'd16);
`endif
    end
    cyc();
    rst = 1'b1;
    #1;
    check("w16.beat5.idx", out_idx16, 4'd5);
    cyc();
    rst        = 1'b0;
    in_valid16 = 1'b1;
    in_data16  = 16'h8000;
    #1;
    check("w16.rst.out_valid", out_valid16, 1'b0);
    check("w16.rst.in_ready", in_ready16, 1'b1);
    check("w16.rst.out_idx", out_idx16, 4'd0);
    check("w16.rst.out_last", out_last16, 1'b0);
    check("w16.rst.out_none", out_none16, 1'b0);
`ifdef BITMAP_ENCODER_COUNT_EN
    check("w16.rst.out_cnt", out_cnt16, 5'd0);
`endif
    cyc();
    in_valid16 = 1'b0;
    #1;
    check("w16.top.valid", out_valid16, 1'b1);
    check("w16.top.idx", out_idx16, 4'd15);
    check("w16.top.last", out_last16, 1'b1);
    check("w16.top.none", out_none16, 1'b0);
    cyc();
    #1;
    check("w16.top.drained", out_valid16, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
